irq_ctrl: RTL

- Parametrised, memory-mapped external interrupt controller for the MIPS microsystem.
- Sits behind the bridge at BASE_ADDR. It collects N_SRC peripheral/testbench interrupt lines, latches them as pending per mode, and masks and priority-encodes them.
- Drives the single interrupt input of the CPU.
- Replaces the single hard-wired interrupt line that is cleared by a write to 0x7F20 with per-source pending/mask/mode/acknowledge.

---
 rtl/irq_ctrl_pkg.sv | 23 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared register map constants and helpers for irq_ctrl
package irq_ctrl_pkg;

    localparam logic [3:0] OFS_PENDING = 4'h0;
    localparam logic [3:0] OFS_MASK    = 4'h4;
    localparam logic [3:0] OFS_MODE    = 4'h8;
    localparam logic [3:0] OFS_ACK     = 4'hC;

    localparam logic [4:0] NO_IRQ  = 5'h1F;
    localparam int         MAX_SRC = 32;

    typedef enum logic [1:0] {
        REG_PENDING = OFS_PENDING[3:2],
        REG_MASK    = OFS_MASK[3:2],
        REG_MODE    = OFS_MODE[3:2],
        REG_ACK     = OFS_ACK[3:2]
    } reg_sel_e;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        byte_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder, id = NO_IRQ when idle
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req_i,
    output logic             valid_o,
    output logic [4:0]       id_o
);

    // Scan downwards so the lowest set index is the last one to win.
    always_comb begin
        valid_o = 1'b0;
        id_o    = NO_IRQ;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                id_o    = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped interrupt controller (pending/mask/mode/ack)
// Optional build macro IRQ_SYNC_EN adds a 2-flop synchroniser on src.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       byteen,
    output logic [31:0]      rdata,
    output logic             irq,
    output logic [4:0]       irq_id
);

    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src;
`endif

    logic     hit;
    logic     wr_en;
    reg_sel_e reg_sel;
    logic [N_SRC-1:0] lane_mask;
    logic [N_SRC-1:0] wdata_n;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = reg_sel_e'(addr[3:2]);
    assign wr_en     = hit && (byteen != 4'b0000);
    assign lane_mask = N_SRC'(byte_mask(byteen));
    assign wdata_n   = N_SRC'(wdata);

    logic       act_valid;
    logic [4:0] act_id;

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio (
        .req_i   (pending_q & mask_q),
        .valid_o (act_valid),
        .id_o    (act_id)
    );

    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] rise;

    assign w1c     = (wr_en && reg_sel == REG_PENDING) ? (wdata_n & lane_mask) : '0;
    assign ack_clr = (wr_en && reg_sel == REG_ACK && act_valid) ? (N_SRC'(1) << act_id) : '0;
    assign clr     = (w1c | ack_clr) & mode_q;
    assign rise    = src_s & ~src_q;

    // Edge bits: a new rising edge beats any clear in the same cycle.
    // Level bits simply track the (possibly synchronised) source.
    always_comb begin
        pending_d = (mode_q & (rise | (pending_q & ~clr))) | (~mode_q & src_s);
        mask_d    = mask_q;
        mode_d    = mode_q;
        if (wr_en && reg_sel == REG_MASK) begin
            mask_d = (mask_q & ~lane_mask) | (wdata_n & lane_mask);
        end
        if (wr_en && reg_sel == REG_MODE) begin
            mode_d = (mode_q & ~lane_mask) | (wdata_n & lane_mask);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
        end else begin
            src_q     <= src_s;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
        end
    end

    assign irq    = act_valid;
    assign irq_id = act_id;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (reg_sel)
                REG_PENDING: rdata = 32'(pending_q);
                REG_MASK:    rdata = 32'(mask_q);
                REG_MODE:    rdata = 32'(mode_q);
                REG_ACK:     rdata = {27'b0, irq_id};
                default:     rdata = '0;
            endcase
        end
    end

    logic unused_bus;
    assign unused_bus = ^{addr[1:0], wdata};

endmodule
